// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and helpers for the IF-stage branch predictor.
//                - 2-bit saturating counter encodings and inc/dec helpers
//                - shadow-pipe entry {pc, pred} carried from IF to MEM
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Widest fetch address the shadow pipe can carry; narrower XLEN
    // instances zero-extend into it.
    localparam int BP_XLEN = 32;

    localparam logic [1:0] SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not taken (reset value)
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               pred;
    } shadow_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_pred_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pred_pipe
//  Description : Three-entry shadow pipe (IF/ID, ID/EX, EX/MEM) that carries
//                each fetch prediction alongside the real pipeline.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_stall       - hold IF/ID, bubble into ID/EX
//                i_flush       - squash all three entries (wins over stall)
//                i_if_entry    - {pc, pred} produced in IF this cycle
//                o_mem_entry   - entry currently aligned with MEM
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_pred_pipe
    import bp_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    input  wire logic    i_stall,
    input  wire logic    i_flush,
    input  wire shadow_t i_if_entry,
    output shadow_t      o_mem_entry
);

    shadow_t r_if_id;
    shadow_t r_id_ex;
    shadow_t r_ex_mem;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_if_id  <= '0;
            r_id_ex  <= '0;
            r_ex_mem <= '0;
        end else begin
            if (!i_stall) begin
                r_if_id <= i_if_entry;
            end
            // A stalled ID stage hands EX a bubble, so the held IF/ID
            // entry is not duplicated downstream.
            r_id_ex  <= i_stall ? '0 : r_if_id;
            r_ex_mem <= r_id_ex;
        end
    end

    assign o_mem_entry = r_ex_mem;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : IF-stage dynamic branch predictor. 2-bit saturating BHT
//                plus direct-mapped BTB indexed by fetch PC, with a shadow
//                pipe that delivers each prediction to MEM for training.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                if_pc              - fetch PC (zero-latency lookup)
//                stall, flush       - pipeline control for the shadow pipe
//                branch_resolved    - MEM holds a resolved conditional branch
//                actual_taken       - its resolved direction
//                mispredict         - MEM prediction was wrong
//                resolve_target     - computed target of the MEM branch
//                pred_taken         - IF prediction (BTB hit && counter[1])
//                pred_target        - BTB target on hit, else 0
//                mem_pred_taken     - prediction of the instruction in MEM
//                branch_count       - saturating resolved-branch count
//                mispredict_count   - saturating mispredict count
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
)(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [XLEN-1:0]  if_pc,
    input  wire logic             stall,
    input  wire logic             flush,
    input  wire logic             branch_resolved,
    input  wire logic             actual_taken,
    input  wire logic             mispredict,
    input  wire logic [XLEN-1:0]  resolve_target,
    output logic                  pred_taken,
    output logic [XLEN-1:0]       pred_target,
    output logic                  mem_pred_taken,
    output logic [CNT_W-1:0]      branch_count,
    output logic [CNT_W-1:0]      mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // ------------------------------------------------------------------
    // Tables
    // ------------------------------------------------------------------
    logic [1:0]        r_cnt    [ENTRIES];
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [XLEN-1:0]   r_target [ENTRIES];

    logic [CNT_W-1:0]  r_branch_count;
    logic [CNT_W-1:0]  r_mispredict_count;

    // ------------------------------------------------------------------
    // Lookup: reads registered state only, so a same-cycle update to the
    // same index is seen on the following cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_hit;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
    // A tag mismatch is a miss regardless of counter strength (aliasing).
    assign w_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign pred_taken  = w_hit && r_cnt[w_if_idx][1];
    assign pred_target = w_hit ? r_target[w_if_idx] : '0;

    // ------------------------------------------------------------------
    // Shadow pipe
    // ------------------------------------------------------------------
    shadow_t w_if_entry;
    shadow_t w_mem_entry;

    always_comb begin
        w_if_entry      = '0;
        w_if_entry.pc   = BP_XLEN'(if_pc);
        w_if_entry.pred = pred_taken;
    end

    bp_pred_pipe u_pred_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_if_entry  (w_if_entry),
        .o_mem_entry (w_mem_entry)
    );

    assign mem_pred_taken = w_mem_entry.pred;

    // ------------------------------------------------------------------
    // Training uses the PC carried to MEM, not the current fetch PC.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  w_mem_pc;
    logic [IDX_W-1:0] w_mem_idx;
    logic [TAG_W-1:0] w_mem_tag;

    assign w_mem_pc  = w_mem_entry.pc[XLEN-1:0];
    assign w_mem_idx = w_mem_pc[IDX_W+1:2];
    assign w_mem_tag = w_mem_pc[XLEN-1:IDX_W+2];

    // Byte-offset bits never participate in indexing or tagging.
    logic w_unused;
    assign w_unused = ^{w_mem_pc[1:0], if_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= WNT;
            end
            r_valid            <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (branch_resolved) begin
            r_cnt[w_mem_idx] <= actual_taken ? sat_inc(r_cnt[w_mem_idx])
                                             : sat_dec(r_cnt[w_mem_idx]);
            if (actual_taken) begin
                r_valid[w_mem_idx] <= 1'b1;
            end
            if (r_branch_count != '1) begin
                r_branch_count <= r_branch_count + CNT_W'(1);
            end
            if (mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    // Tag/target payload needs no reset: it is only observed behind valid.
    always_ff @(posedge clk) begin
        if (!rst && branch_resolved && actual_taken) begin
            r_tag[w_mem_idx]    <= w_mem_tag;
            r_target[w_mem_idx] <= resolve_target;
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench for branch_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 4;   // small so counter saturation is reachable

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  if_pc;
    logic             stall;
    logic             flush;
    logic             branch_resolved;
    logic             actual_taken;
    logic             mispredict;
    logic [XLEN-1:0]  resolve_target;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             mem_pred_taken;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .stall            (stall),
        .flush            (flush),
        .branch_resolved  (branch_resolved),
        .actual_taken     (actual_taken),
        .mispredict       (mispredict),
        .resolve_target   (resolve_target),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .mem_pred_taken   (mem_pred_taken),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch pc, let it travel to MEM (3 edges), then resolve it on the 4th.
    task automatic resolve(input logic [31:0] pc, input logic taken, input logic misp);
        if_pc = pc;
        step();
        if_pc = 32'h204;
        step();
        step();
        branch_resolved = 1'b1;
        actual_taken    = taken;
        mispredict      = misp;
        resolve_target  = 32'h80;
        step();
        branch_resolved = 1'b0;
        actual_taken    = 1'b0;
        mispredict      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_pc = '0; stall = 1'b0; flush = 1'b0;
        branch_resolved = 1'b0; actual_taken = 1'b0; mispredict = 1'b0;
        resolve_target = '0;
        step();
        step();
        rst = 1'b0;

        // ---- reset state ----
        if_pc = 32'h100;
        #1;
        chk("rst_pred_taken",  32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'h0);
        chk("rst_mem_pred",    32'(mem_pred_taken), 32'd0);
        chk("rst_cnt0",        32'(dut.r_cnt[0]), 32'h1);
        chk("rst_cnt63",       32'(dut.r_cnt[63]), 32'h1);
        chk("rst_bcount",      32'(branch_count), 32'd0);

        // ---- first taken resolve at 0x100 -> WT, BTB valid ----
        resolve(32'h100, 1'b1, 1'b1);
        chk("train_cnt0", 32'(dut.r_cnt[0]), 32'h2);
        if_pc = 32'h100;
        #1;
        chk("train_pred_taken",  32'(pred_taken), 32'd1);
        chk("train_pred_target", pred_target, 32'h80);
        step();
        if_pc = 32'h204;
        step();
        chk("lat_2cyc", 32'(mem_pred_taken), 32'd0);
        step();
        chk("lat_3cyc", 32'(mem_pred_taken), 32'd1);
        step();
        chk("lat_4cyc", 32'(mem_pred_taken), 32'd0);

        // ---- saturation ----
        for (int i = 0; i < 4; i++) resolve(32'h100, 1'b1, 1'b0);
        chk("sat_st", 32'(dut.r_cnt[0]), 32'h3);
        resolve(32'h100, 1'b0, 1'b1);
        if_pc = 32'h100;
        #1;
        chk("sat_wt_cnt",  32'(dut.r_cnt[0]), 32'h2);
        chk("sat_wt_pred", 32'(pred_taken), 32'd1);
        for (int i = 0; i < 3; i++) resolve(32'h100, 1'b0, 1'b0);
        if_pc = 32'h100;
        #1;
        chk("sat_snt_cnt",    32'(dut.r_cnt[0]), 32'h0);
        chk("sat_snt_pred",   32'(pred_taken), 32'd0);
        chk("sat_snt_target", pred_target, 32'h80);
        chk("sat_bcount",     32'(branch_count), 32'd9);
        chk("sat_mcount",     32'(mispredict_count), 32'd2);

        // ---- reset mid-operation with a resolve in MEM ----
        if_pc = 32'h100;
        step();
        if_pc = 32'h204;
        step();
        step();
        branch_resolved = 1'b1; actual_taken = 1'b1; mispredict = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0; branch_resolved = 1'b0; actual_taken = 1'b0; mispredict = 1'b0;
        if_pc = 32'h100;
        #1;
        chk("midrst_cnt0",   32'(dut.r_cnt[0]), 32'h1);
        chk("midrst_target", pred_target, 32'h0);
        chk("midrst_bcount", 32'(branch_count), 32'd0);
        chk("midrst_mcount", 32'(mispredict_count), 32'd0);
        chk("midrst_mem",    32'(mem_pred_taken), 32'd0);

        // ---- perf counters: 5 resolves, 2 mispredicts ----
        resolve(32'h100, 1'b1, 1'b1);
        resolve(32'h100, 1'b1, 1'b0);
        resolve(32'h100, 1'b1, 1'b0);
        resolve(32'h100, 1'b0, 1'b1);
        resolve(32'h100, 1'b0, 1'b0);
        chk("perf_bcount", 32'(branch_count), 32'd5);
        chk("perf_mcount", 32'(mispredict_count), 32'd2);
        chk("perf_cnt0",   32'(dut.r_cnt[0]), 32'h1);
        resolve(32'h100, 1'b1, 1'b0);   // back to WT

        // ---- mispredict without branch_resolved is ignored ----
        mispredict = 1'b1; actual_taken = 1'b1;
        step();
        mispredict = 1'b0; actual_taken = 1'b0;
        chk("ign_bcount", 32'(branch_count), 32'd6);
        chk("ign_mcount", 32'(mispredict_count), 32'd2);
        chk("ign_cnt0",   32'(dut.r_cnt[0]), 32'h2);

        // ---- aliasing ----
        if_pc = 32'h100 + 32'(4 * ENTRIES);
        #1;
        chk("alias_pred",   32'(pred_taken), 32'd0);
        chk("alias_target", pred_target, 32'h0);
        if_pc = 32'h100;
        #1;
        chk("alias_home_pred", 32'(pred_taken), 32'd1);

        // ---- stall one cycle: MEM sees the prediction after 4 edges ----
        if_pc = 32'h100;
        step();
        if_pc = 32'h204;
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        chk("stall_3cyc", 32'(mem_pred_taken), 32'd0);
        step();
        chk("stall_4cyc", 32'(mem_pred_taken), 32'd1);
        step();

        // ---- flush (with stall) at cycle 2 squashes the prediction ----
        if_pc = 32'h100;
        step();
        if_pc = 32'h204;
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        step();
        chk("flush_3cyc", 32'(mem_pred_taken), 32'd0);
        step();
        chk("flush_4cyc", 32'(mem_pred_taken), 32'd0);
        step();
        chk("flush_5cyc", 32'(mem_pred_taken), 32'd0);

        // ---- same-cycle resolve and fetch of the same PC ----
        if_pc = 32'h100;
        step();
        if_pc = 32'h204;
        step();
        step();
        if_pc = 32'h100;
        branch_resolved = 1'b1; actual_taken = 1'b0; mispredict = 1'b1;
        resolve_target = 32'h80;
        #1;
        chk("same_old_pred", 32'(pred_taken), 32'd1);
        step();
        branch_resolved = 1'b0; mispredict = 1'b0;
        chk("same_new_pred", 32'(pred_taken), 32'd0);
        chk("same_bcount",   32'(branch_count), 32'd7);
        chk("same_mcount",   32'(mispredict_count), 32'd3);

        // ---- perf counter saturation at all-ones ----
        for (int i = 0; i < 13; i++) begin
            resolve(32'h100, 1'b1, 1'b1);
            if (i == 9) begin
                chk("psat_bcount_mid", 32'(branch_count), 32'd15);
                chk("psat_mcount_mid", 32'(mispredict_count), 32'd13);
            end
        end
        chk("psat_bcount", 32'(branch_count), 32'd15);
        chk("psat_mcount", 32'(mispredict_count), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
